cdc_sync_data_scheduler: RTL and testbench
==========================================

Name: cdc_sync_data_scheduler

Overview:
- Source-domain scheduler that shares one cdc_sync_data_open instance between NUM_REQ requesters, such as timestamp capture, sample count and overflow flags.
- Arbitrates round-robin and tags each word with the requester ID.
- Drives the synchronizer's one-cycle enable pulse and holds the bus stable for HOLDOFF cycles, so the destination domain always samples a settled word.
- Sits in util_cpack2_timestamp, clocked by the source-side clock.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 16, payload bits per requester
ID_WIDTH, 2, requester tag width; 2**ID_WIDTH >= NUM_REQ
HOLDOFF, 4, cycles sync_bits held stable after the launch cycle (>=1)

Ports:
clk  in  1  source-domain clock
resetn  in  1  asynchronous active-low reset
en  in  1  1 = new grants allowed; 0 = in-flight transfer completes, no new grant
req  in  NUM_REQ  level request per requester; held until ack
req_data  in  NUM_REQ*DATA_WIDTH  requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
ack  out  NUM_REQ  one-cycle pulse: requester's data captured
sync_enable  out  1  to cdc_sync_data_open.enable; one-cycle pulse per transfer
sync_bits  out  ID_WIDTH+DATA_WIDTH  to cdc_sync_data_open.bits_in; {id, data}
busy  out  1  1 while in LAUNCH or HOLD
grant_id  out  ID_WIDTH  ID of the most recent grant

Behaviour:
- Reset (async assert, sync release): ack=0, sync_enable=0, sync_bits=0, busy=0, grant_id=0, state=IDLE, round-robin pointer=0, hold counter=0.
- All outputs are registered.
- States: IDLE, LAUNCH, HOLD.
- IDLE: if en=1 and req!=0, select the winner combinationally (see round-robin below).
  - Next edge: state=LAUNCH, sync_enable=1, ack[w]=1, sync_bits={w, req_data[w]}, grant_id=w, busy=1, pointer=w+1 mod NUM_REQ.
- Round-robin: the winner is the first set req bit starting at the pointer and wrapping.
- Latency: req sampled high in IDLE -> sync_enable/ack high on the following cycle.
- LAUNCH: lasts exactly 1 cycle; sync_enable and ack drop to 0 on exit; counter loaded to HOLDOFF-1; state=HOLD.
- HOLD: lasts exactly HOLDOFF cycles.
  - sync_bits is frozen for the whole LAUNCH+HOLD window.
  - The counter decrements each cycle.
  - In the cycle the counter=0, arbitrate as in IDLE. If en=1 and a request is pending, go directly to LAUNCH with the new winner; otherwise go to IDLE with busy=0.
- Back-to-back throughput: one transfer per 1+HOLDOFF cycles (5 at defaults).
- sync_bits retains its last value in IDLE; it changes only on a LAUNCH entry edge.
- Simultaneous requests resolve round-robin; no requester is granted twice while another is continuously requesting.
- Requester i must keep req[i] and req_data high/stable until ack[i]. A req dropped before ack is simply not considered; there is no latching or error.
- req[i] still high in the cycle after ack is treated as a new request.
- en falling during LAUNCH/HOLD: the current transfer completes, then IDLE.
- en=0 in IDLE: no grant and no ack, regardless of req.
- Reset mid-transfer: all outputs immediately 0. The destination may have seen a partial enable; requesters re-request after reset release.
- Unused ID codes (>= NUM_REQ) are never emitted.

Test Plan:
1. Single request: reset, then req=4'b0100, data[2]=16'hBEEF. Required: sync_enable and ack[2] high exactly 1 cycle, one cycle after req sampled; sync_bits=18'h2BEEF held 5 cycles; busy high 5 cycles; grant_id=2.
2. Simultaneous requests: req=4'b1111 held, each dropped on its ack. Required: grant order 0,1,2,3; sync_enable pulses spaced exactly 5 cycles; sync_bits IDs 0,1,2,3.
3. Fairness: req[0] and req[3] held high continuously. Required: grants alternate 0,3,0,3 and never repeat the same ID consecutively.
4. Enable gating: en=0 with req=4'b0010 for 10 cycles -> no ack, sync_enable=0. Set en=1 -> grant of ID 1 next cycle. Drop en during HOLD -> transfer completes, no further grants.
5. Reset mid-HOLD: assert resetn=0 two cycles into HOLD. Required: all outputs 0 asynchronously. After release, a pending req[3] grants ID 3 first, because the pointer reset to 0 and reqs 0..2 are low.
6. Loopback with cdc_sync_data_open (clk_out 3x faster, out of phase): 4 requesters with distinct data. Required: destination valid/bits_out deliver all four {id, data} words intact, in grant order.

Source files
------------

// File: rtl/cdc_sync_data_scheduler.sv
// Round-robin scheduler sharing one open-loop CDC data synchronizer between NUM_REQ requesters.
// Latency: req sampled in IDLE -> sync_enable/ack on the next cycle; one transfer per 1+HOLDOFF cycles.
// Backpressure: requesters hold req/data until ack; en=0 blocks new grants but lets the current transfer finish.
module cdc_sync_data_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 2,
    parameter int HOLDOFF    = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           en,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           sync_enable,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] sync_bits,
    output logic                           busy,
    output logic [ID_WIDTH-1:0]            grant_id
);

    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} state_t;

    state_t                         state, state_nxt;
    logic [ID_WIDTH-1:0]            ptr, ptr_nxt;
    logic [CNT_W-1:0]               cnt, cnt_nxt;
    logic                           win_vld;
    logic [ID_WIDTH-1:0]            win_id;
    logic                           launch;
    logic [NUM_REQ-1:0]             ack_nxt;
    logic                           sync_enable_nxt;
    logic [ID_WIDTH+DATA_WIDTH-1:0] sync_bits_nxt;
    logic                           busy_nxt;
    logic [ID_WIDTH-1:0]            grant_id_nxt;

    // First set request at or after the pointer, wrapping; ptr is always < NUM_REQ.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        cnt_nxt         = cnt;
        ack_nxt         = '0;
        sync_enable_nxt = 1'b0;
        sync_bits_nxt   = sync_bits;
        busy_nxt        = busy;
        grant_id_nxt    = grant_id;
        launch          = 1'b0;
        case (state)
            IDLE: begin
                if (en && win_vld) launch = 1'b1;
            end
            LAUNCH: begin
                state_nxt = HOLD;
                cnt_nxt   = CNT_W'(HOLDOFF - 1);
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (en && win_vld) begin
                    launch = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (launch) begin
            state_nxt       = LAUNCH;
            sync_enable_nxt = 1'b1;
            ack_nxt         = NUM_REQ'(1) << win_id;
            sync_bits_nxt   = {win_id, req_data[win_id*DATA_WIDTH +: DATA_WIDTH]};
            grant_id_nxt    = win_id;
            busy_nxt        = 1'b1;
            ptr_nxt         = (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + ID_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            ack         <= '0;
            sync_enable <= 1'b0;
            sync_bits   <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
            ack         <= ack_nxt;
            sync_enable <= sync_enable_nxt;
            sync_bits   <= sync_bits_nxt;
            busy        <= busy_nxt;
            grant_id    <= grant_id_nxt;
        end
    end

endmodule

// File: tb/tb_cdc_sync_data_scheduler.sv
// Directed bench for cdc_sync_data_scheduler, including a behavioural open-loop
// synchronizer on a 3x faster, out-of-phase destination clock for loopback.
`timescale 1ns/1ps
module tb_cdc_sync_data_scheduler;

    logic        clk = 1'b0;
    logic        clk_out = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  ack;
    logic        sync_enable;
    logic [17:0] sync_bits;
    logic        busy;
    logic [1:0]  grant_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit auto_drop = 1'b1;

    logic [1:0]  gq[$];
    int          cq[$];
    logic [17:0] bq[$];
    logic [17:0] dq[$];

    cdc_sync_data_scheduler dut (
        .clk         (clk),
        .resetn      (resetn),
        .en          (en),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .sync_enable (sync_enable),
        .sync_bits   (sync_bits),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;
    initial begin
        #0.7;
        forever #1.667 clk_out = ~clk_out;
    end

    // Destination side: toggle launched in the source domain, 2-flop sync, edge detect captures bits.
    logic        tgl, s1, s2, s3, dst_vld;
    logic [17:0] dst_bits;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tgl <= 1'b0;
        else if (sync_enable) tgl <= ~tgl;
    end
    always_ff @(posedge clk_out or negedge resetn) begin
        if (!resetn) begin
            s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0; dst_vld <= 1'b0; dst_bits <= '0;
        end else begin
            s1 <= tgl; s2 <= s1; s3 <= s2;
            dst_vld <= s2 ^ s3;
            if (s2 ^ s3) dst_bits <= sync_bits;
        end
    end
    always @(posedge clk_out) if (dst_vld) dq.push_back(dst_bits);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (sync_enable) begin
            gq.push_back(grant_id);
            cq.push_back(cyc);
            bq.push_back(sync_bits);
        end
        if (auto_drop) req = req & ~ack;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        tick();
        tick();
        resetn = 1'b1;
        gq.delete(); cq.delete(); bq.delete();
    endtask

    initial begin
        int n_busy, n_en, n_bad;
        en = 1'b1;
        #1;
        // Reset state
        check("rst_ack", 32'(ack), 0);
        check("rst_sen", 32'(sync_enable), 0);
        check("rst_bits", 32'(sync_bits), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_gid", 32'(grant_id), 0);
        do_reset();

        // 1: single request
        req_data[2*16 +: 16] = 16'hBEEF;
        req = 4'b0100;
        tick();
        check("t1_sen", 32'(sync_enable), 1);
        check("t1_ack", 32'(ack), 32'h4);
        check("t1_bits", 32'(sync_bits), 32'h2BEEF);
        check("t1_gid", 32'(grant_id), 2);
        n_busy = 0; n_en = 0; n_bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            n_busy += int'(busy);
            n_en += int'(sync_enable);
            if (sync_bits !== 18'h2BEEF) n_bad++;
        end
        check("t1_busy_cyc", 32'(n_busy), 5);
        check("t1_sen_cyc", 32'(n_en), 1);
        check("t1_bits_held", 32'(n_bad), 0);
        check("t1_ack_idle", 32'(ack), 0);

        // 2: simultaneous requests, each dropped on its ack
        do_reset();
        for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = 16'h1000 + 16'(i);
        req = 4'b1111;
        for (int i = 0; i < 25; i++) tick();
        check("t2_n", 32'(gq.size()), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) begin
            check($sformatf("t2_gid%0d", i), 32'(gq[i]), 32'(i));
            check($sformatf("t2_bits%0d", i), 32'(bq[i]), {14'd0, 2'(i), 16'h1000 + 16'(i)});
            if (i > 0) check($sformatf("t2_gap%0d", i), 32'(cq[i] - cq[i-1]), 5);
        end

        // 3: fairness with req[0] and req[3] held continuously
        do_reset();
        auto_drop = 1'b0;
        req = 4'b1001;
        for (int i = 0; i < 20; i++) tick();
        check("t3_n", 32'(gq.size()), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            check($sformatf("t3_gid%0d", i), 32'((i % 2 == 0) ? 0 : 3), 32'(gq[i]));
        req = '0;
        auto_drop = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("t3_idle", 32'(busy), 0);

        // 4: enable gating
        do_reset();
        en = 1'b0;
        req = 4'b0010;
        n_en = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_en += int'(sync_enable) + int'(ack != 0);
        end
        check("t4_gated", 32'(n_en), 0);
        en = 1'b1;
        tick();
        check("t4_sen", 32'(sync_enable), 1);
        check("t4_gid", 32'(grant_id), 1);
        req = 4'b0001;
        tick();
        en = 1'b0;
        gq.delete();
        for (int i = 0; i < 10; i++) tick();
        check("t4_no_more", 32'(gq.size()), 0);
        check("t4_busy_end", 32'(busy), 0);
        req = '0;
        en = 1'b1;

        // 5: reset two cycles into HOLD
        req_data[1*16 +: 16] = 16'h5555;
        req_data[3*16 +: 16] = 16'hC0DE;
        req = 4'b0010;
        tick();
        tick();
        tick();
        tick();
        resetn = 1'b0;
        #1;
        check("t5_ack", 32'(ack), 0);
        check("t5_sen", 32'(sync_enable), 0);
        check("t5_bits", 32'(sync_bits), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_gid", 32'(grant_id), 0);
        req = 4'b1000;
        tick();
        resetn = 1'b1;
        tick();
        check("t5_regrant", 32'(sync_enable), 1);
        check("t5_gid3", 32'(grant_id), 3);
        check("t5_bits3", 32'(sync_bits), 32'h3C0DE);
        for (int i = 0; i < 6; i++) tick();

        // 6: loopback through the behavioural synchronizer
        do_reset();
        dq.delete();
        for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = 16'hA5A0 ^ (16'(i) << 12) ^ 16'(i * 3);
        req = 4'b1111;
        for (int i = 0; i < 28; i++) tick();
        check("t6_n", 32'(dq.size()), 4);
        for (int i = 0; i < 4 && i < dq.size(); i++)
            check($sformatf("t6_word%0d", i), 32'(dq[i]),
                  {14'd0, 2'(i), 16'hA5A0 ^ (16'(i) << 12) ^ 16'(i * 3)});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
